button_scan_debounce: RTL and testbench
=======================================

Name: button_scan_debounce

Overview:
- Input-side counterpart to the LED running-light pattern generator. It reads the board push-buttons (active-low, mechanically bouncing), synchronises and debounces them on a slow sample tick, and emits clean levels plus single-cycle press, release and auto-repeat pulses.
- Its outputs feed the pattern/shift control logic (start/stop, speed, direction).

Parameters:
- N_BTN, 4: number of button inputs (1..8).
- TICK_DIV, 17'd100000: clk cycles per sample tick (2..131071); 1 ms at 100 MHz.
- STABLE_N, 4'd4: consecutive differing samples required to flip a debounced level (1..15).
- HOLD_TICKS, 8'd200: ticks a button must stay pressed before auto-repeat starts (1..255).
- REPEAT_TICKS, 8'd50: ticks between auto-repeat pulses (1..255).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high; clears all state.
- btn_n, input, N_BTN: raw buttons, active-low (0 = pressed), asynchronous to clk.
- btn_level, output, N_BTN: debounced state, active-high (1 = pressed).
- btn_press, output, N_BTN: one-clk pulse when the debounced level rises 0->1.
- btn_release, output, N_BTN: one-clk pulse when the debounced level falls 1->0.
- btn_repeat, output, N_BTN: one-clk pulse per auto-repeat event while held.
- tick, output, 1: one-clk sample strobe, for downstream timing.

Behaviour:
- Reset values:
  - btn_level, btn_press, btn_release, btn_repeat and tick all 0.
  - Synchroniser flops all 1 (released).
  - Tick counter 0; integrators 0; hold counters 0; every FSM in IDLE.
- Reset asserted mid-operation clears everything immediately. No pulse is emitted on reset entry or exit.
- Synchroniser: a 2-flop chain per bit. The sample value is s = ~sync2.
- Tick generator:
  - Free-running 17-bit counter, 0..TICK_DIV-1, wrapping to 0.
  - tick = 1 for exactly the cycle where the counter equals TICK_DIV-1.
  - All per-button logic below advances only in tick cycles and holds otherwise.
- Integrator, per button, on each tick:
  - If s == btn_level: cnt <= 0.
  - Else if cnt == STABLE_N-1: btn_level <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A single glitch sample resets progress. STABLE_N = 1 flips on the first differing sample.
- Edge pulses:
  - btn_press and btn_release are registered. They are high for the one clk cycle after the tick edge that changed btn_level, aligned with the first cycle of the new level.
  - Otherwise they are 0. The press and release outputs of one button are never both high.
- Auto-repeat FSM, per button, transitions on tick only:
  - IDLE: on level rising -> HELD, hold_cnt <= 0.
  - HELD:
    - Level 0 -> IDLE.
    - hold_cnt == HOLD_TICKS-1 -> REPEAT, rpt_cnt <= 0, pulse btn_repeat.
    - Else hold_cnt++.
  - REPEAT:
    - Level 0 -> IDLE, with no repeat pulse on that tick.
    - rpt_cnt == REPEAT_TICKS-1 -> pulse btn_repeat, rpt_cnt <= 0.
    - Else rpt_cnt++.
  - HELD and REPEAT count ticks after the press tick. The first repeat pulse occurs HOLD_TICKS ticks after btn_press.
  - btn_repeat never coincides with btn_press. On the release tick, btn_release takes priority and btn_repeat stays 0.
- Buttons are fully independent. Simultaneous presses yield simultaneous pulses on their own bits.
- Latency from a clean btn_n edge to the btn_level change: 2 clk (sync) + (STABLE_N-1)*TICK_DIV + up to TICK_DIV clk alignment.
- Counters saturate nowhere; every counter is bounded by its compare value.

Test Plan:
- TICK_DIV=4, STABLE_N=3; drive btn_n[0] 1->0 cleanly -> btn_level[0] rises on the 3rd tick after sync, btn_press[0] is exactly 1 clk wide, the other bits stay 0.
- Same params; btn_n[1] low for 2 samples, high for 1, then low for 3 -> the level rises only after the final 3-sample run; exactly one press pulse in total.
- HOLD_TICKS=5, REPEAT_TICKS=2; hold btn 2 for 12 ticks after press -> btn_repeat pulses at press+5, +7, +9, +11 ticks. On release, btn_release pulses and no repeat follows.
- Press btn 0 and btn 3 in the same cycle -> btn_press = 4'b1001 in a single cycle; release only btn 3 -> btn_release = 4'b1000, btn_level = 4'b0001.
- Assert reset while btn 1 is in REPEAT -> all outputs 0 within the same cycle. Deassert with btn held -> after STABLE_N ticks a fresh btn_press[1] pulses, with no spurious release.
- Tick check: TICK_DIV=4 -> tick is high on every 4th cycle, 1 clk wide, first assertion 4 cycles after reset release.

Source files
------------

// File: rtl/button_scan_debounce.sv
// Push-button front end: synchronise, debounce on a slow tick,
// and emit clean levels plus press, release and auto-repeat pulses.
module button_scan_debounce #(
  parameter int unsigned N_BTN        = 4,
  parameter logic [16:0] TICK_DIV     = 17'd100000,
  parameter logic [3:0]  STABLE_N     = 4'd4,
  parameter logic [7:0]  HOLD_TICKS   = 8'd200,
  parameter logic [7:0]  REPEAT_TICKS = 8'd50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             tick
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [16:0]      div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign tick = (div_cnt == TICK_DIV - 17'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 17'd1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic       s;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       lvl_q;
    logic       lvl_nxt;
    logic       press_q;
    logic       rel_q;
    logic       rep_q;
    logic       rpt_fire;
    logic       rise;
    rpt_state_e state;
    rpt_state_e state_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic [7:0] rpt_cnt;
    logic [7:0] rpt_nxt;

    assign s    = ~sync2[i];
    assign rise = lvl_nxt & ~lvl_q;

    // Any sample agreeing with the level discards accumulated progress.
    always_comb begin
      cnt_nxt = cnt;
      lvl_nxt = lvl_q;
      if (tick) begin
        if (s == lvl_q) begin
          cnt_nxt = '0;
        end else if (cnt == STABLE_N - 4'd1) begin
          lvl_nxt = s;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt     <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        cnt     <= cnt_nxt;
        lvl_q   <= lvl_nxt;
        press_q <= rise;
        rel_q   <= lvl_q & ~lvl_nxt;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state    <= IDLE;
        hold_cnt <= '0;
        rpt_cnt  <= '0;
        rep_q    <= 1'b0;
      end else begin
        state    <= state_nxt;
        hold_cnt <= hold_nxt;
        rpt_cnt  <= rpt_nxt;
        rep_q    <= rpt_fire;
      end
    end

    always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      rpt_nxt   = rpt_cnt;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              state_nxt = HELD;
              hold_nxt  = '0;
            end
          end
          HELD: begin
            if (!lvl_nxt) begin
              state_nxt = IDLE;
            end else if (hold_cnt == HOLD_TICKS - 8'd1) begin
              state_nxt = REPEAT;
              rpt_nxt   = '0;
            end else begin
              hold_nxt = hold_cnt + 8'd1;
            end
          end
          REPEAT: begin
            if (!lvl_nxt) begin
              state_nxt = IDLE;
            end else if (rpt_cnt == REPEAT_TICKS - 8'd1) begin
              rpt_nxt = '0;
            end else begin
              rpt_nxt = rpt_cnt + 8'd1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end

    // Release on this tick suppresses any repeat that was due.
    always_comb begin
      rpt_fire = 1'b0;
      if (tick && lvl_nxt) begin
        unique case (state)
          HELD:    rpt_fire = (hold_cnt == HOLD_TICKS - 8'd1);
          REPEAT:  rpt_fire = (rpt_cnt == REPEAT_TICKS - 8'd1);
          default: rpt_fire = 1'b0;
        endcase
      end
    end

    assign btn_level[i]   = lvl_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_repeat[i]  = rep_q;
  end

endmodule

// File: tb/tb_button_scan_debounce.sv
// Bench for button_scan_debounce: vector table, hand sequences and
// random stimulus against a sample-window reference model.
module tb_button_scan_debounce;
  localparam int NB = 4;
  localparam int TD = 4;
  localparam int SN = 3;
  localparam int HT = 5;
  localparam int RT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_n = '1;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;
  logic          tick;

  button_scan_debounce #(
    .N_BTN(NB),
    .TICK_DIV(17'(TD)),
    .STABLE_N(4'(SN)),
    .HOLD_TICKS(8'(HT)),
    .REPEAT_TICKS(8'(RT))
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_repeat(btn_repeat),
    .tick(tick)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference model: a level flips once the last SN tick samples all
  // disagree with it; repeats fall on press+HT+k*RT ticks.
  int            m_cyc;
  int            m_ticks;
  int            nsamp;
  logic [NB-1:0] h1, h2;
  logic [15:0]   shist [NB];
  int            press_t [NB];
  logic [NB-1:0] e_lvl, e_press, e_rel, e_rep;
  logic          e_tick;

  task automatic model_reset();
    m_cyc = 0; m_ticks = 0; nsamp = 0;
    h1 = '1; h2 = '1;
    e_lvl = '0; e_press = '0; e_rel = '0; e_rep = '0; e_tick = 1'b0;
    for (int i = 0; i < NB; i++) begin
      shist[i] = '0;
      press_t[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [NB-1:0] b);
    logic [NB-1:0] s;
    int d;
    e_press = '0; e_rel = '0; e_rep = '0;
    if ((m_cyc % TD) == TD - 1) begin
      s = ~h2;
      m_ticks++;
      nsamp++;
      for (int i = 0; i < NB; i++) begin
        shist[i] = {shist[i][14:0], s[i]};
        if (nsamp >= SN && shist[i][SN-1:0] == {SN{~e_lvl[i]}}) begin
          e_lvl[i] = ~e_lvl[i];
          if (e_lvl[i]) begin
            e_press[i] = 1'b1;
            press_t[i] = m_ticks;
          end else begin
            e_rel[i] = 1'b1;
          end
        end else if (e_lvl[i]) begin
          d = m_ticks - press_t[i];
          if (d >= HT && ((d - HT) % RT) == 0) e_rep[i] = 1'b1;
        end
      end
    end
    h2 = h1;
    h1 = b;
    m_cyc++;
    e_tick = ((m_cyc % TD) == TD - 1);
  endtask

  logic [NB-1:0] obs_p, obs_r, obs_rep;

  task automatic step(input logic [NB-1:0] b);
    btn_n = b;
    @(posedge clk);
    model_edge(b);
    #1;
    chk("level", 32'(btn_level), 32'(e_lvl));
    chk("press", 32'(btn_press), 32'(e_press));
    chk("release", 32'(btn_release), 32'(e_rel));
    chk("repeat", 32'(btn_repeat), 32'(e_rep));
    chk("tick", 32'(tick), 32'(e_tick));
    obs_p   |= btn_press;
    obs_r   |= btn_release;
    obs_rep |= btn_repeat;
  endtask

  task automatic blocks(input logic [NB-1:0] b, input int n);
    repeat (4 * n) step(b);
  endtask

  typedef struct {
    logic [NB-1:0] b;
    int            nblk;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] rep;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    int first_tick;
    int n_ticks;
    logic [15:0] rep_mask;
    logic [15:0] rel_mask;

    tbl[0]  = '{4'b1110, 3, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1111, 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[3]  = '{4'b0110, 3, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1110, 3, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
    tbl[5]  = '{4'b1111, 3, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    tbl[6]  = '{4'b1101, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1101, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1101, 1, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1111, 3, 4'b0000, 4'b0000, 4'b0010, 4'b0000};

    model_reset();
    #1;
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_press", 32'(btn_press), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Tick spacing straight out of reset.
    first_tick = -1;
    n_ticks = 0;
    for (int c = 1; c <= 12; c++) begin
      step(4'b1111);
      if (tick) begin
        n_ticks++;
        if (first_tick < 0) first_tick = c;
      end
    end
    chk("tick_first", 32'(first_tick), 32'd3);
    chk("tick_count", 32'(n_ticks), 32'd3);

    for (int r = 0; r < 11; r++) begin
      obs_p = '0; obs_r = '0; obs_rep = '0;
      blocks(tbl[r].b, tbl[r].nblk);
      chk($sformatf("row%0d_lvl", r), 32'(btn_level), 32'(tbl[r].lvl));
      chk($sformatf("row%0d_press", r), 32'(obs_p), 32'(tbl[r].prs));
      chk($sformatf("row%0d_rel", r), 32'(obs_r), 32'(tbl[r].rel));
      chk($sformatf("row%0d_rep", r), 32'(obs_rep), 32'(tbl[r].rep));
    end

    // Auto-repeat on button 2: held 12 ticks, released over ticks 13-15.
    obs_p = '0;
    blocks(4'b1011, 3);
    chk("rpt_press", 32'(obs_p), 32'(4'b0100));
    rep_mask = '0;
    rel_mask = '0;
    for (int k = 1; k <= 15; k++) begin
      obs_rep = '0; obs_r = '0;
      blocks((k <= 12) ? 4'b1011 : 4'b1111, 1);
      rep_mask[k] = obs_rep[2];
      rel_mask[k] = obs_r[2];
    end
    chk("rpt_ticks", 32'(rep_mask), 32'h2aa0);
    chk("rpt_release", 32'(rel_mask), 32'h8000);
    obs_rep = '0;
    blocks(4'b1111, 3);
    chk("rpt_after_rel", 32'(obs_rep), 32'd0);

    // Reset while button 1 sits in the repeat state.
    blocks(4'b1101, 9);
    chk("pre_rst_level", 32'(btn_level), 32'(4'b0010));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_level", 32'(btn_level), 32'd0);
    chk("mid_rst_press", 32'(btn_press), 32'd0);
    chk("mid_rst_release", 32'(btn_release), 32'd0);
    chk("mid_rst_repeat", 32'(btn_repeat), 32'd0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    obs_p = '0; obs_r = '0;
    blocks(4'b1101, 5);
    chk("post_rst_press", 32'(obs_p), 32'(4'b0010));
    chk("post_rst_rel", 32'(obs_r), 32'd0);
    chk("post_rst_level", 32'(btn_level), 32'(4'b0010));

    // Random bouncing and holding, checked every cycle.
    begin
      logic [NB-1:0] cur;
      cur = 4'b1111;
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 5) == 0)
          cur[$urandom_range(0, NB - 1)] ^= 1'b1;
        step(cur);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
